// File: rtl/cim_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : cim_mem_arb_if
//  Description : Requester-side bus of the CiM arbitrated memory. Per-requester
//                request, access type, address and write data are packed
//                vectors; grant, read-valid and write-error are one-hot.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cim_mem_arb_if #(
    parameter int N_REQ  = 6,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        wen_i;
    logic [N_REQ*ADDR_W-1:0] addr_i;
    logic [N_REQ*DATA_W-1:0] wdata_i;
    logic [N_REQ-1:0]        gnt_o;
    logic [N_REQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]       rdata_o;
    logic [N_REQ-1:0]        wr_err_o;

    // Requester side
    modport master (
        output req_i, wen_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, wr_err_o
    );

    // Memory/arbiter side
    modport slave (
        input  req_i, wen_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, wr_err_o
    );
endinterface
`default_nettype wire

// File: rtl/cim_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cim_mem_arb
//  Description : Single-port storage with a built-in N-way arbiter. Grant is
//                combinational and one-hot; the granted access executes on
//                the edge ending the grant cycle. Registered read data with
//                1 or 2 cycles of latency, per-requester write permission,
//                and a saturating contention counter.
//                Optional macro CIM_MEM_ARB_RR_EN selects round-robin
//                arbitration; when undefined, lowest index has priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module cim_mem_arb #(
    parameter int               N_REQ    = 6,
    parameter int               DATA_W   = 16,
    parameter int               DEPTH    = 528,
    parameter int               READ_LAT = 1,
    parameter logic [N_REQ-1:0] WR_MASK  = 6'b111011
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    cim_mem_arb_if.slave     bus,
    output      logic [15:0] conflict_cnt_o
);

    localparam int               ADDR_W  = $clog2(DEPTH);
    localparam logic [N_REQ-1:0] ONE_N   = N_REQ'(1);
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_cand;
    logic [N_REQ-1:0]  w_gnt;
    logic              w_any;
    logic              w_sel_wen;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_wr_ok;
    logic              w_oob;
    logic              w_do_wr;
    logic              w_do_rd;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_multi;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [N_REQ-1:0]  rv1_q;
    logic [DATA_W-1:0] rd1_q;
    logic [N_REQ-1:0]  wr_err_q;
    logic [15:0]       conflict_cnt_q;

    assign w_req = bus.req_i;

`ifdef CIM_MEM_ARB_RR_EN
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // rr_ptr_q is the first index searched: one past the last winner.
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [N_REQ-1:0] w_hi_req;

    // Requests at or above the pointer win first; otherwise wrap to the bottom.
    assign w_hi_req = w_req & ~((ONE_N << rr_ptr_q) - ONE_N);
    assign w_cand   = (|w_hi_req) ? w_hi_req : w_req;

    // Next search start follows the current winner.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                rr_ptr_d = (i == N_REQ - 1) ? '0 : IDX_W'(i + 1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign w_cand = w_req;
`endif

    // Isolate the lowest set candidate bit; reset blocks every grant.
    assign w_gnt     = rst_n ? (w_cand & (~w_cand + ONE_N)) : '0;
    assign w_any     = |w_gnt;
    assign bus.gnt_o = w_gnt;

    // Route the winner's access fields onto the single memory port.
    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_wr_ok     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_wen   = bus.wen_i[i];
                w_sel_addr  = bus.addr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.wdata_i[i*DATA_W +: DATA_W];
                w_wr_ok     = WR_MASK[i];
            end
        end
    end

    assign w_oob     = ({1'b0, w_sel_addr} >= DEPTH_V);
    assign w_do_wr   = w_any & w_sel_wen & w_wr_ok & ~w_oob;
    assign w_do_rd   = w_any & ~w_sel_wen;
    assign w_rd_word = w_oob ? '0 : mem_q[w_sel_addr];
    assign w_multi   = |(w_req & (w_req - ONE_N));

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[w_sel_addr] <= w_sel_wdata;
        end
    end

    // First read stage, write-error pulse and contention counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rv1_q          <= '0;
            rd1_q          <= '0;
            wr_err_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rv1_q    <= w_do_rd ? w_gnt : '0;
            wr_err_q <= (w_any & w_sel_wen & ~w_wr_ok) ? w_gnt : '0;
            if (w_do_rd) begin
                rd1_q <= w_rd_word;
            end
            if (w_multi && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [N_REQ-1:0]  rv2_q;
            logic [DATA_W-1:0] rd2_q;

            // Extra output stage; data only moves when a read completes.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rv2_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rv2_q <= rv1_q;
                    if (|rv1_q) begin
                        rd2_q <= rd1_q;
                    end
                end
            end

            assign bus.rvalid_o = rv2_q;
            assign bus.rdata_o  = rd2_q;
        end else begin : g_lat1
            assign bus.rvalid_o = rv1_q;
            assign bus.rdata_o  = rd1_q;
        end
    endgenerate

    assign bus.wr_err_o   = wr_err_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule
`default_nettype wire
